// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock from a precomputed key schedule.
// Bus bit 0 (MSB of byte 0) is bit 127 here; round 0 key sits in the top 128 bits of words_i.
// Define AES_CIPHER_ITER_DBG_EN to expose the round counter and state register.
module aes_cipher_iter #(
  parameter int unsigned KEY_BITS = 128,
  localparam int unsigned NR = KEY_BITS / 32 + 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [127:0]          in_i,
  input  logic [128*(NR+1)-1:0] words_i,
  output logic [127:0]          out_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
`ifdef AES_CIPHER_ITER_DBG_EN
  ,
  output logic [3:0]            dbg_round_o,
  output logic [127:0]          dbg_state_o
`endif
);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_key_bits_check
    $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  state_e       fsm_q;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [127:0] out_q;
  logic         in_ready_q;
  logic         busy_q;
  logic         out_valid_q;

  logic [127:0] rk;
  logic [127:0] sr;
  logic [127:0] mc;

  always_comb begin
    rk = '0;
    for (int unsigned r = 0; r <= NR; r++) begin
      if (round_q == 4'(r)) rk = words_i[128*(NR-r) +: 128];
    end
    sr = shift_rows(sub_bytes(state_q));
    mc = mix_columns(sr);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q       <= StIdle;
      round_q     <= '0;
      state_q     <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            state_q    <= in_i ^ words_i[128*NR +: 128];
            round_q    <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= StRun;
          end
        end
        StRun: begin
          if (round_q < 4'(NR)) begin
            state_q <= mc ^ rk;
            round_q <= round_q + 4'd1;
          end else if (round_q == 4'(NR)) begin
            out_q       <= sr ^ rk;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= StDone;
          end else begin
            // Unreachable count: abandon the block rather than run past the schedule.
            round_q    <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            fsm_q      <= StIdle;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= StIdle;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          fsm_q       <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;

`ifdef AES_CIPHER_ITER_DBG_EN
  assign dbg_round_o = round_q;
  assign dbg_state_o = state_q;
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: one instance per key size, known-answer vectors,
// randomized blocks against a byte-level AES model, backpressure and mid-run reset.
module tb_aes_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [2:0]          iv;
  logic [2:0]          ordy;
  logic [127:0]        din;
  logic [128*11-1:0]   w128;
  logic [128*13-1:0]   w192;
  logic [128*15-1:0]   w256;
  logic                irdy [3];
  logic                ov   [3];
  logic                bsy  [3];
  logic [127:0]        dout [3];
`ifdef AES_CIPHER_ITER_DBG_EN
  logic [3:0]          dr   [3];
  logic [127:0]        ds   [3];
`endif

  aes_cipher_iter #(.KEY_BITS(128)) u_aes128 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(irdy[0]), .in_i(din),
    .words_i(w128), .out_o(dout[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
    .busy_o(bsy[0])
`ifdef AES_CIPHER_ITER_DBG_EN
    , .dbg_round_o(dr[0]), .dbg_state_o(ds[0])
`endif
  );

  aes_cipher_iter #(.KEY_BITS(192)) u_aes192 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(irdy[1]), .in_i(din),
    .words_i(w192), .out_o(dout[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
    .busy_o(bsy[1])
`ifdef AES_CIPHER_ITER_DBG_EN
    , .dbg_round_o(dr[1]), .dbg_state_o(ds[1])
`endif
  );

  aes_cipher_iter #(.KEY_BITS(256)) u_aes256 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[2]), .in_ready_o(irdy[2]), .in_i(din),
    .words_i(w256), .out_o(dout[2]), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
    .busy_o(bsy[2])
`ifdef AES_CIPHER_ITER_DBG_EN
    , .dbg_round_o(dr[2]), .dbg_state_o(ds[2])
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_t [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Full schedule, round r key at bits [1919-128*r -: 128]; key occupies the top nk words.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    r  = '0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      r[1919-32*i -: 32] = w[i];
    end
    return r;
  endfunction

  // State after round `upto` (0 = initial key addition; nr = ciphertext).
  function automatic logic [127:0] ref_state(input logic [127:0] pt, input logic [1919:0] wb,
                                             input int nr, input int upto);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ wb[1919-8*i -: 8];
    for (int r = 1; r <= upto; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * ((i / 4 + i % 4) % 4)]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) begin
            s[4*c+row] = gmul(t[4*c+row], 8'h02) ^ gmul(t[4*c+(row+1)%4], 8'h03) ^
                         t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
          end
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ wb[1919-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers / checkers ----------------
  task automatic set_words(input int k, input logic [1919:0] wb);
    case (k)
      0:       w128 = wb[1919 -: 1408];
      1:       w192 = wb[1919 -: 1664];
      default: w256 = wb;
    endcase
  endtask

  task automatic start_block(input int k, input string name, input logic [127:0] pt,
                             input logic [1919:0] wb);
    @(negedge clk);
    set_words(k, wb);
    din = pt;
    chk({name, " in_ready idle"}, irdy[k], 1'b1);
    iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    din = rnd128();
  endtask

  // Call between the accept edge and the next edge; `skip` edges already elapsed.
  task automatic await_result(input int k, input string name, input logic [127:0] pt,
                              input logic [1919:0] wb, input logic [127:0] exp, input int skip);
    int   n;
    logic seen;
    n    = skip;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = ov[k];
      if (n == 1) chk({name, " busy run"}, bsy[k], 1'b1);
`ifdef AES_CIPHER_ITER_DBG_EN
      if (!seen && n < 10 + 2 * k) begin
        chk($sformatf("%s dbg_state r%0d", name, n), ds[k], ref_state(pt, wb, 10 + 2 * k, n));
        chk($sformatf("%s dbg_round r%0d", name, n), dr[k], 128'(n + 1));
      end
`endif
    end
    chk({name, " latency"}, 128'(n), 128'(10 + 2 * k));
    chk({name, " out"}, dout[k], exp);
    chk({name, " busy done"}, bsy[k], 1'b0);
    chk({name, " in_ready done"}, irdy[k], 1'b0);
  endtask

  task automatic drain(input int k, input int hold, input string name, input logic [127:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, " hold valid"}, ov[k], 1'b1);
      chk({name, " hold out"}, dout[k], exp);
      chk({name, " hold in_ready"}, irdy[k], 1'b0);
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    @(negedge clk);
    chk({name, " valid cleared"}, ov[k], 1'b0);
    chk({name, " in_ready back"}, irdy[k], 1'b1);
    chk({name, " out retained"}, dout[k], exp);
  endtask

  task automatic run_block(input int k, input string name, input logic [127:0] pt,
                           input logic [1919:0] wb, input logic [127:0] exp, input int hold);
    start_block(k, name, pt, wb);
    await_result(k, name, pt, wb, exp, 0);
    drain(k, hold, name, exp);
  endtask

  typedef struct {
    int           k;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] PtB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KeyB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  initial begin
    vec_t          vecs [4];
    logic [1919:0] wb;
    logic [1919:0] wbb;
    logic [255:0]  key;
    logic [127:0]  pt;
    logic [127:0]  pt2;
    logic          seen;

    build_sbox();
    vecs[0] = '{0, KeyB, PtB, CtB};
    vecs[1] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    din   = '0;
    w128  = '0;
    w192  = '0;
    w256  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset out k%0d", k), dout[k], '0);
      chk($sformatf("reset out_valid k%0d", k), ov[k], 1'b0);
      chk($sformatf("reset busy k%0d", k), bsy[k], 1'b0);
      chk($sformatf("reset in_ready k%0d", k), irdy[k], 1'b1);
`ifdef AES_CIPHER_ITER_DBG_EN
      chk($sformatf("reset dbg_round k%0d", k), dr[k], '0);
      chk($sformatf("reset dbg_state k%0d", k), ds[k], '0);
`endif
    end

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].k, $sformatf("vec%0d", i), vecs[i].pt,
                expand(vecs[i].key, 4 + 2 * vecs[i].k), vecs[i].ct, i % 3);
    end

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        key = {rnd128(), rnd128()};
        pt  = rnd128();
        wb  = expand(key, 4 + 2 * k);
        run_block(k, $sformatf("rand k%0d #%0d", k, j), pt, wb, ref_state(pt, wb, 10 + 2 * k,
                  10 + 2 * k), int'($urandom_range(0, 3)));
      end
    end

`ifdef AES_CIPHER_ITER_DBG_EN
    wbb = expand(KeyB, 4);
    start_block(0, "appb dbg", PtB, wbb);
    @(posedge clk);
    @(negedge clk);
    chk("appb dbg_state round1", ds[0], 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("appb dbg_round round1", dr[0], 128'd2);
    await_result(0, "appb dbg", PtB, wbb, CtB, 1);
    drain(0, 0, "appb dbg", CtB);
`endif

    // Backpressure with in_valid held high throughout.
    wbb = expand(KeyB, 4);
    pt2 = rnd128();
    @(negedge clk);
    set_words(0, wbb);
    din   = PtB;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    await_result(0, "bp first", PtB, wbb, CtB, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp hold valid", ov[0], 1'b1);
      chk("bp hold out", dout[0], CtB);
      chk("bp hold in_ready", irdy[0], 1'b0);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    din     = pt2;
    @(negedge clk);
    chk("bp not taken on handshake edge", bsy[0], 1'b0);
    chk("bp in_ready after handshake", irdy[0], 1'b1);
    chk("bp valid cleared", ov[0], 1'b0);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("bp second accepted", bsy[0], 1'b1);
    await_result(0, "bp second", pt2, wbb, ref_state(pt2, wbb, 10, 10), 0);
    drain(0, 0, "bp second", ref_state(pt2, wbb, 10, 10));

    // Reset in the middle of a block.
    start_block(0, "midrst", PtB, wbb);
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef AES_CIPHER_ITER_DBG_EN
    chk("midrst dbg_round", dr[0], 128'd5);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst out", dout[0], '0);
    chk("midrst out_valid", ov[0], 1'b0);
    chk("midrst busy", bsy[0], 1'b0);
    chk("midrst in_ready", irdy[0], 1'b1);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seen = seen | ov[0] | bsy[0];
    end
    chk("midrst nothing emitted", seen, 1'b0);
    run_block(0, "after reset", PtB, wbb, CtB, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Parametrised iterative AES encryption core. Handles AES-128, AES-192 or AES-256, selected at elaboration.
- Computes one round per clock from a precomputed key schedule, using the existing add_round_key, sub_bytes, shift_rows and MixColumns blocks.
- Sits between the key-expansion block, which supplies the words bus, and the block-level datapath.
- Uses valid/ready handshakes on both input and output, a round-counter FSM, and an explicit done indication.

Parameters:
- KEY_BITS, 128, key size: 128, 192 or 256. Any other value is an elaboration error.
- NR, derived (KEY_BITS/32+6), number of rounds: 10, 12 or 14. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  plaintext block present.
- in_ready  out  1  core can accept a block.
- in  in  128  plaintext, bit 0 = MSB of byte 0 (big-endian [0:127]).
- words  in  128*(NR+1)  round keys; round r is at bits [128*r +: 128].
- out  out  128  ciphertext, same bit ordering as in.
- out_valid  out  1  out holds a completed ciphertext.
- out_ready  in  1  consumer accepts out.
- busy  out  1  rounds in progress.

Behaviour:
- Reset, sampled on the rising clk edge when rst_n=0:
  - FSM goes to IDLE; round=0; state reg=0.
  - out=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
  - Reset mid-operation aborts the block silently; nothing is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid&&in_ready: state <= in ^ words[0+:128]; round <= 1; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - If round<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ key[round]; round <= round+1.
  - If round==NR: out <= ShiftRows(SubBytes(state)) ^ key[NR]; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - out is held stable until out_valid&&out_ready, then go to IDLE (out_valid <= 0, out retains its value).
  - out_ready is ignored in every state other than DONE.
- Latency:
  - Accept edge is E0; out_valid rises after edge E0+NR (10/12/14 cycles).
  - Minimum issue interval is NR+2 cycles (one DONE cycle plus one IDLE cycle).
- words must stay stable from the accept edge until out_valid. The core does not latch the schedule. Changing words mid-run corrupts the result; this is allowed but undefined.
- in is sampled only on the accept edge; later changes are ignored.
- in_valid held high while in_ready=0 has no effect; the block is taken on the next IDLE cycle.
- round is a 4-bit counter with no wrap. Values above NR are unreachable; if ever reached, the FSM returns to IDLE.
- All registers update with nonblocking assignments only; there are no combinational paths from in_valid or out_ready to outputs.

Optional Feature:
- Macro: AES_CIPHER_ITER_DBG_EN.
- When defined, two extra output ports are added:
  - dbg_round (4 bits): the current round register.
  - dbg_state (128 bits): the state register after each edge.
- Both ports are 0 under reset, and the bench uses them for per-round comparison against FIPS-197 intermediate values.
- When undefined, the ports are absent and the logic is identical otherwise. There is no timing or latency difference.

Test Plan:
- AES-128 (FIPS-197 App. B): in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c expanded into words -> out=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- KEY_BITS=192: in=00112233445566778899aabbccddeeff, key 000102…1617 -> out=dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
- KEY_BITS=256: same plaintext, key 000102…1e1f -> out=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out and out_valid are stable and in_ready=0; a second in_valid pulse is not accepted until the cycle after the out handshake. Back-to-back blocks each produce correct output.
- Reset mid-run: assert rst_n=0 at round 5 -> next cycle out=0, out_valid=0, busy=0, in_ready=1. A fresh block then encrypts correctly.
- With AES_CIPHER_ITER_DBG_EN (AES-128, App. B vectors): dbg_state after round 1 = a49c7ff2689f352b6b5bea43026a5049 and dbg_round=2.
